// File: rtl/chronos_pkg.sv
// Shared types for the memory-port arbiter between fetch and load/store.
package chronos_pkg;

    localparam int XLEN = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_t;

    typedef enum logic [0:0] {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: fetch and load/store share one memory port,
// with one transaction in flight at a time and a starvation guard for fetch.
//
// state | meaning
// IDLE  | no transaction outstanding; a request is granted in this cycle
// WAIT  | one transaction issued; waiting for mem_rvalid from memory
module mem_arbiter
    import chronos_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,

    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [XLEN-1:0] ls_addr,
    input  logic [XLEN-1:0] ls_wdata,
    output logic            ls_gnt,
    output logic            ls_rvalid,
    output logic [XLEN-1:0] ls_rdata,

    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int            SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_t      state_q, state_d;
    arb_owner_t      owner_q, owner_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;

    logic            pick_if;
    logic            pick_ls;
    logic            rsp_accept;

    // Arbitration: load/store wins by default, fetch wins when alone or starved.
    // Gated by rst so no grant is visible while reset is held.
    always_comb begin
        pick_if = 1'b0;
        pick_ls = 1'b0;
        if (rst && (state_q == IDLE)) begin
            if (if_req && (!ls_req || (starve_q == STARVE_MAX))) begin
                pick_if = 1'b1;
            end else if (ls_req) begin
                pick_ls = 1'b1;
            end
        end
    end

    // A response counts only after mem_req has been presented (mem_req_q low in WAIT).
    assign rsp_accept = (state_q == WAIT) && !mem_req_q && mem_rvalid;

    // Next-state: latch owner and request fields on grant, return to IDLE on response.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (pick_if) begin
            state_d     = WAIT;
            owner_d     = OWN_IF;
            starve_d    = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
        end else if (pick_ls) begin
            state_d     = WAIT;
            owner_d     = OWN_LS;
            mem_req_d   = 1'b1;
            mem_we_d    = ls_we;
            mem_addr_d  = ls_addr;
            mem_wdata_d = ls_wdata;
            if (if_req && (starve_q != STARVE_MAX)) begin
                starve_d = starve_q + SW'(1);
            end
        end else if (rsp_accept) begin
            state_d = IDLE;
        end
    end

    // State and registered memory-port outputs; reset abandons any open transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            starve_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign if_gnt    = pick_if;
    assign ls_gnt    = pick_ls;
    assign if_rvalid = rsp_accept && (owner_q == OWN_IF);
    assign ls_rvalid = rsp_accept && (owner_q == OWN_LS);
    assign if_rdata  = mem_rdata;
    assign ls_rdata  = mem_rdata;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle model with scoreboard queues plus directed scenarios.
module tb_mem_arbiter;
    import chronos_pkg::*;

    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid;
    logic [31:0] if_rdata, ls_rdata;
    logic        mem_req, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .ls_req     (ls_req),
        .ls_we      (ls_we),
        .ls_addr    (ls_addr),
        .ls_wdata   (ls_wdata),
        .ls_gnt     (ls_gnt),
        .ls_rvalid  (ls_rvalid),
        .ls_rdata   (ls_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0F0F);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Memory model: answers mem_delay cycles after the mem_req cycle.
    int          mem_delay = 1;
    logic        force_rv  = 1'b0;
    logic        rsp_pend  = 1'b0;
    int          rsp_cnt   = 0;
    logic [31:0] rsp_addr  = '0;

    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_rvalid = force_rv;
            mem_rdata  = force_rv ? 32'hBAD0_BAD0 : 32'h0;
            force_rv   = 1'b0;
            if (rsp_pend) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_fn(rsp_addr);
                    rsp_pend   = 1'b0;
                end
            end
            if (mem_req) begin
                rsp_pend = 1'b1;
                rsp_cnt  = mem_delay;
                rsp_addr = mem_addr;
            end
        end
    end

    // Reference model and scoreboard, evaluated mid-cycle.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct packed {
        logic        is_if;
        logic [31:0] data;
    } rsp_exp_t;

    mem_exp_t exp_mem[$];
    rsp_exp_t exp_rsp[$];
    logic     m_busy   = 1'b0;
    logic     m_issue  = 1'b0;
    logic     m_own_if = 1'b0;
    int       m_starve = 0;

    always @(negedge clk) begin : model
        logic     e_if, e_ls, e_acc;
        mem_exp_t me;
        rsp_exp_t re;
        if (!rst) begin
            chk("rst_ctrl_outs", 32'({if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_req, mem_we}), 32'h0);
            chk("rst_mem_addr", mem_addr, 32'h0);
            chk("rst_mem_wdata", mem_wdata, 32'h0);
            m_busy   = 1'b0;
            m_issue  = 1'b0;
            m_starve = 0;
            exp_mem.delete();
            exp_rsp.delete();
        end else begin
            e_if  = 1'b0;
            e_ls  = 1'b0;
            e_acc = 1'b0;
            if (!m_busy) begin
                if (if_req && (!ls_req || m_starve == STARVE_LIMIT)) e_if = 1'b1;
                else if (ls_req) e_ls = 1'b1;
            end else if (!m_issue && mem_rvalid) begin
                e_acc = 1'b1;
            end
            chk("if_gnt", 32'(if_gnt), 32'(e_if));
            chk("ls_gnt", 32'(ls_gnt), 32'(e_ls));
            chk("if_rvalid", 32'(if_rvalid), 32'(e_acc && m_own_if));
            chk("ls_rvalid", 32'(ls_rvalid), 32'(e_acc && !m_own_if));
            chk("mem_req", 32'(mem_req), 32'(m_issue));
            if (mem_req) begin
                if (exp_mem.size() == 0) begin
                    chk("mem_sb_underflow", 32'h1, 32'h0);
                end else begin
                    me = exp_mem.pop_front();
                    chk("mem_we", 32'(mem_we), 32'(me.we));
                    chk("mem_addr", mem_addr, me.addr);
                    chk("mem_wdata", mem_wdata, me.wdata);
                end
            end
            if (if_rvalid || ls_rvalid) begin
                if (exp_rsp.size() == 0) begin
                    chk("rsp_sb_underflow", 32'h1, 32'h0);
                end else begin
                    re = exp_rsp.pop_front();
                    chk("rsp_owner_if", 32'(if_rvalid), 32'(re.is_if));
                    chk("rsp_if_rdata", if_rdata, re.data);
                    chk("rsp_ls_rdata", ls_rdata, re.data);
                end
            end
            m_issue = 1'b0;
            if (e_if) begin
                exp_mem.push_back('{we: 1'b0, addr: if_addr, wdata: 32'h0});
                exp_rsp.push_back('{is_if: 1'b1, data: mem_fn(if_addr)});
                m_busy = 1'b1; m_issue = 1'b1; m_own_if = 1'b1; m_starve = 0;
            end else if (e_ls) begin
                exp_mem.push_back('{we: ls_we, addr: ls_addr, wdata: ls_wdata});
                exp_rsp.push_back('{is_if: 1'b0, data: mem_fn(ls_addr)});
                m_busy = 1'b1; m_issue = 1'b1; m_own_if = 1'b0;
                if (if_req && m_starve < STARVE_LIMIT) m_starve++;
            end else if (e_acc) begin
                m_busy = 1'b0;
            end
        end
    end

    task automatic wait_gnt(output logic got_if, output logic got_ls);
        int n = 0;
        got_if = 1'b0;
        got_ls = 1'b0;
        while (n < 40) begin
            @(negedge clk);
            if (if_gnt || ls_gnt) begin
                got_if = if_gnt;
                got_ls = ls_gnt;
                return;
            end
            n++;
        end
        chk("gnt_timeout", 32'h0, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic g_if, g_ls;
        int   rv_cnt, gnt_cnt, k;
        logic exp_order [6];
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        rst = 1'b0;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
        repeat (3) cyc();
        if_req = 1'b1;
        @(negedge clk);
        chk("rst_no_gnt", 32'(if_gnt), 32'h0);
        cyc();
        if_req = 1'b0;
        rst = 1'b1;
        repeat (2) cyc();
        chk("rst_state_idle", 32'(dut.state_q), 32'(IDLE));
        chk("rst_starve", 32'(dut.starve_q), 32'h0);

        // Fetch only, memory answers one cycle after mem_req
        if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        chk("t1_if_gnt_c0", 32'(if_gnt), 32'h1);
        cyc();
        if_req = 1'b0;
        @(negedge clk);
        chk("t1_mem_req_c1", 32'(mem_req), 32'h1);
        chk("t1_mem_addr_c1", mem_addr, 32'h100);
        chk("t1_mem_we_c1", 32'(mem_we), 32'h0);
        cyc();
        @(negedge clk);
        chk("t1_if_rvalid_c2", 32'(if_rvalid), 32'h1);
        chk("t1_if_rdata_c2", if_rdata, 32'hDEAD_BEEF);
        chk("t1_ls_rvalid_c2", 32'(ls_rvalid), 32'h0);
        cyc();

        // Simultaneous requests: store wins, fetch follows
        if_req = 1'b1; if_addr = 32'h300;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h200; ls_wdata = 32'h55;
        @(negedge clk);
        chk("t2_ls_gnt", 32'(ls_gnt), 32'h1);
        chk("t2_if_gnt", 32'(if_gnt), 32'h0);
        cyc();
        ls_req = 1'b0;
        @(negedge clk);
        chk("t2_mem_we", 32'(mem_we), 32'h1);
        chk("t2_mem_wdata", mem_wdata, 32'h55);
        chk("t2_mem_addr", mem_addr, 32'h200);
        cyc();
        @(negedge clk);
        chk("t2_ls_rvalid", 32'(ls_rvalid), 32'h1);
        cyc();
        @(negedge clk);
        chk("t2_if_gnt_next", 32'(if_gnt), 32'h1);
        cyc();
        if_req = 1'b0;
        repeat (3) cyc();

        // Starvation: both held high
        ls_we = 1'b0; ls_addr = 32'h1000; if_addr = 32'h2000;
        if_req = 1'b1; ls_req = 1'b1;
        for (int g = 0; g < 6; g++) begin
            wait_gnt(g_if, g_ls);
            chk($sformatf("t3_gnt%0d_is_if", g), 32'(g_if), 32'(exp_order[g]));
            chk($sformatf("t3_gnt%0d_any", g), 32'(g_if || g_ls), 32'h1);
            cyc();
            if (g_if) begin
                if_addr = if_addr + 32'h4;
                @(negedge clk);
                chk("t3_starve_clr", 32'(dut.starve_q), 32'h0);
            end else begin
                ls_addr = ls_addr + 32'h4;
            end
        end
        if_req = 1'b0; ls_req = 1'b0;
        repeat (4) cyc();

        // Reset while waiting; late response must vanish
        mem_delay = 5;
        if_req = 1'b1; if_addr = 32'h400;
        @(negedge clk);
        chk("t4_if_gnt", 32'(if_gnt), 32'h1);
        cyc();
        if_req = 1'b0;
        @(negedge clk);
        chk("t4_mem_req", 32'(mem_req), 32'h1);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("t4_state_rst", 32'(dut.state_q), 32'(IDLE));
        cyc();
        rst = 1'b1;
        rv_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (if_rvalid || ls_rvalid) rv_cnt++;
        end
        chk("t4_no_rvalid", 32'(rv_cnt), 32'h0);
        chk("t4_state_idle", 32'(dut.state_q), 32'(IDLE));
        mem_delay = 1;

        // Spurious response in IDLE
        force_rv = 1'b1;
        cyc();
        @(negedge clk);
        chk("t5_no_if_rvalid", 32'(if_rvalid), 32'h0);
        chk("t5_no_ls_rvalid", 32'(ls_rvalid), 32'h0);
        chk("t5_state_idle", 32'(dut.state_q), 32'(IDLE));
        cyc();

        // Slow memory: fetch held high through a long wait
        mem_delay = 10;
        if_req = 1'b1; if_addr = 32'h500;
        @(negedge clk);
        chk("t6_if_gnt", 32'(if_gnt), 32'h1);
        gnt_cnt = 0; rv_cnt = 0; k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (if_gnt || ls_gnt) gnt_cnt++;
            if (if_rvalid || ls_rvalid) begin
                rv_cnt++;
                k = i;
                break;
            end
        end
        cyc();
        if_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (if_rvalid || ls_rvalid) rv_cnt++;
        end
        chk("t6_gnt_in_wait", 32'(gnt_cnt), 32'h0);
        chk("t6_rvalid_pulses", 32'(rv_cnt), 32'h1);
        chk("t6_latency", 32'(k), 32'd11);
        repeat (12) cyc();

        // Random traffic with varying memory latency
        g_if = 1'b0; g_ls = 1'b0;
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (g_if) if_req = 1'b0;
            if (g_ls) ls_req = 1'b0;
            mem_delay = $urandom_range(1, 3);
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req  = 1'b1;
                if_addr = $urandom;
            end
            if (!ls_req && $urandom_range(0, 2) == 0) begin
                ls_req   = 1'b1;
                ls_we    = 1'($urandom_range(0, 1));
                ls_addr  = $urandom;
                ls_wdata = $urandom;
            end
            @(negedge clk);
            g_if = if_gnt;
            g_ls = ls_gnt;
        end
        cyc();
        if_req = 1'b0; ls_req = 1'b0;
        repeat (10) cyc();
        chk("sb_mem_empty", 32'(exp_mem.size()), 32'h0);
        chk("sb_rsp_empty", 32'(exp_rsp.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one parameter, STARVE_LIMIT, default 4, which sets the number of consecutive load/store grants allowed while fetch waits.
REQ-002 The block SHALL have one clock and asynchronous active-low reset: clk in 1 (rising edge), rst in 1 (asynchronous, active-low).
REQ-003 The fetch port SHALL be: if_req in 1 (fetch request), if_addr in 32 (word address), if_gnt out 1 (request accepted), if_rvalid out 1 (fetch data valid), if_rdata out 32 (fetch data).
REQ-004 The load/store port SHALL be: ls_req in 1, ls_we in 1 (1 = store), ls_addr in 32, ls_wdata in 32, ls_gnt out 1, ls_rvalid out 1 (load data valid or store acknowledge), ls_rdata out 32.
REQ-005 The memory port SHALL be: mem_req out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_rvalid in 1 (response or acknowledge), mem_rdata in 32.

Function
REQ-006 The block SHALL share one memory port between the fetch and load/store requesters, with at most one transaction outstanding.
REQ-007 The block SHALL implement a two-state FSM, IDLE and WAIT, and the reset state SHALL be IDLE.
REQ-008 In IDLE with at least one request high, the block SHALL assert exactly one of if_gnt/ls_gnt combinationally in that cycle, latch the owner and request fields, and move to WAIT.
REQ-009 The arbitration SHALL follow these rules:
- ls wins by default.
- if wins when only if_req is high.
- if wins when if_req is high and the starve count equals STARVE_LIMIT.
REQ-010 The starve counter SHALL behave as follows:
- Width is clog2(STARVE_LIMIT+1).
- +1 on an ls grant while if_req is high.
- Cleared on an if grant.
- Saturates at STARVE_LIMIT.
- Unchanged otherwise.
REQ-011 The memory request outputs SHALL behave as follows:
- mem_req, mem_we, mem_addr and mem_wdata are registered.
- mem_req is high for exactly one cycle, the cycle after the grant.
- For a fetch grant, mem_we = 0 and mem_wdata = 0.
REQ-012 In WAIT, when mem_rvalid = 1 the block SHALL pulse the owner's rvalid for one cycle in the same cycle (combinational) and return to IDLE; if_rdata and ls_rdata SHALL both equal mem_rdata.
REQ-013 The non-owner rvalid SHALL remain 0.
REQ-014 Gnt SHALL never be asserted in WAIT, and requesters SHALL hold req and fields until gnt.
REQ-015 Timing SHALL be: minimum latency req→rvalid is 2 cycles (gnt at cycle 0, mem_req at 1, rvalid at 2 at earliest); the next grant occurs no earlier than the cycle after rvalid.
REQ-016 mem_rvalid received in IDLE, or in the mem_req cycle of WAIT, SHALL be ignored with no rvalid output.
REQ-017 WAIT SHALL have no timeout; the block SHALL remain in WAIT until mem_rvalid.
REQ-018 A request deasserted before grant SHALL be dropped, with no side effects.

Reset
REQ-019 While rst = 0 the block SHALL force the following values:
- State is IDLE.
- Starve counter is 0.
- mem_req = mem_we = 0.
- mem_addr = mem_wdata = 0.
- if_gnt = ls_gnt = 0.
- if_rvalid = ls_rvalid = 0.
REQ-020 Reset asserted during WAIT SHALL abandon the outstanding transaction, and no rvalid SHALL be produced for it after release.
REQ-021 The first grant after reset release SHALL occur no earlier than the first rising clk edge with rst = 1.

Structure
REQ-022 A shared package chronos_pkg SHALL hold the FSM state type {IDLE, WAIT}, the owner type {OWN_IF, OWN_LS}, and the 32-bit XLEN constant.
REQ-023 The block SHALL have no sub-modules; the starve counter and FSM SHALL be inline, and the block SHALL be instantiable between the instruction fetch stage and inst_mem.

Verification
REQ-024 Fetch only: if_req = 1, if_addr = 0x100, with memory responding one cycle after mem_req with 0xDEADBEEF → if_gnt at c0, mem_req/mem_addr = 0x100/mem_we = 0 at c1, if_rvalid with if_rdata = 0xDEADBEEF at c2, ls_rvalid = 0 throughout.
REQ-025 Simultaneous requests: if_req and ls_req high (ls_we = 1, ls_addr = 0x200, ls_wdata = 0x55) → ls_gnt first, mem_we = 1, mem_wdata = 0x55; after ls_rvalid, if_gnt on the next IDLE cycle if ls_req is dropped.
REQ-026 Starvation: ls_req and if_req held high continuously with STARVE_LIMIT = 4 → grant order ls,ls,ls,ls,if,ls…, and the counter reads 0 after the if grant.
REQ-027 Reset mid-transaction: rst = 0 in WAIT, then released, then mem_rvalid pulsed → no if_rvalid/ls_rvalid, state IDLE, all outputs 0 during reset.
REQ-028 Spurious response: mem_rvalid = 1 in IDLE with no requests → no rvalid outputs and no state change.
REQ-029 Slow memory: mem_rvalid delayed 10 cycles → gnt held 0 for 10 cycles despite if_req = 1, and exactly one rvalid pulse.
